// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block handshake, key-schedule and round-datapath signals of the AES round sequencer.
interface aes_round_ctrl_if;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_block_i;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic [127:0] rnd_state_o;
    logic         mix_en_o;
    logic [127:0] rnd_result_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_block_o;
    logic         busy_o;
    modport master (
        input  flush_i, in_valid_i, in_block_i, rk_i, rnd_result_i, out_ready_i,
        output in_ready_o, rk_idx_o, rnd_state_o, mix_en_o, out_valid_o, out_block_o, busy_o
    );
    modport slave (
        output flush_i, in_valid_i, in_block_i, rk_i, rnd_result_i, out_ready_i,
        input  in_ready_o, rk_idx_o, rnd_state_o, mix_en_o, out_valid_o, out_block_o, busy_o
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer; initial AddRoundKey on accept, then NR external rounds.
module aes_round_ctrl #(
    parameter int NR = 14
) (
    input logic             clk,
    input logic             rst_n,
    aes_round_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t       state, state_nx;
    logic [127:0] state_reg, state_reg_nx;
    logic [3:0]   round, round_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            state_reg <= '0;
            round     <= '0;
        end else begin
            state     <= state_nx;
            state_reg <= state_reg_nx;
            round     <= round_nx;
        end
    end

    // flush wins over every transition, including an accept in IDLE
    always_comb begin
        state_nx     = state;
        state_reg_nx = state_reg;
        round_nx     = round;
        if (bus.flush_i) begin
            state_nx     = IDLE;
            state_reg_nx = '0;
            round_nx     = '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid_i) begin
                    state_reg_nx = bus.in_block_i ^ bus.rk_i;
                    round_nx     = 4'd1;
                    state_nx     = ROUND;
                end
                ROUND: begin
                    state_reg_nx = bus.rnd_result_i;
                    if (round == 4'(NR)) state_nx = DONE;
                    else round_nx = round + 4'd1;
                end
                DONE: if (bus.out_ready_i) begin
                    state_nx = IDLE;
                    round_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = state == IDLE;
    assign bus.busy_o      = state != IDLE;
    assign bus.out_valid_o = state == DONE;
    assign bus.rk_idx_o    = state == ROUND ? round : 4'd0;
    assign bus.mix_en_o    = state == ROUND && round != 4'(NR);
    assign bus.rnd_state_o = state_reg;
    assign bus.out_block_o = state_reg;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: AES-256 and AES-128 builds of the round sequencer against a software AES model.
module tb_aes_round_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    aes_round_ctrl_if b14();
    aes_round_ctrl_if b10();
    aes_round_ctrl #(.NR(14)) u14 (.clk(clk), .rst_n(rst_n), .bus(b14));
    aes_round_ctrl #(.NR(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         iv, ordy, flush, sel;
    logic [127:0] blk;
    logic         ov, ir, bz, mix;
    logic [3:0]   rk_idx;
    logic [127:0] ob, rs;
    logic [127:0] ks14 [16];
    logic [127:0] ks10 [16];

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sb(logic [7:0] a);
        logic [7:0] x = 8'h01;
        logic [7:0] s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            x = gmul(x, s);
        end
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(logic [255:0] key, int nk, int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*r+4; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] rnd(logic [127:0] s, logic m, logic [127:0] k);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sb(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        b = t;
        if (m)
            for (int c = 0; c < 4; c++) begin
                b[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                b[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                b[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
            end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(logic [127:0] pt, bit w10);
        int nr = w10 ? 10 : 14;
        logic [127:0] s = pt ^ (w10 ? ks10[0] : ks14[0]);
        for (int r = 1; r <= nr; r++) s = rnd(s, r != nr, w10 ? ks10[r] : ks14[r]);
        return s;
    endfunction

    // key-schedule storage and single-round datapath seen by each DUT
    assign b14.rk_i         = ks14[b14.rk_idx_o];
    assign b10.rk_i         = ks10[b10.rk_idx_o];
    assign b14.rnd_result_i = rnd(b14.rnd_state_o, b14.mix_en_o, b14.rk_i);
    assign b10.rnd_result_i = rnd(b10.rnd_state_o, b10.mix_en_o, b10.rk_i);
    assign b14.in_valid_i   = iv & ~sel;
    assign b10.in_valid_i   = iv & sel;
    assign b14.in_block_i   = blk;
    assign b10.in_block_i   = blk;
    assign b14.out_ready_i  = ordy;
    assign b10.out_ready_i  = ordy;
    assign b14.flush_i      = flush;
    assign b10.flush_i      = flush;
    assign ov     = sel ? b10.out_valid_o : b14.out_valid_o;
    assign ir     = sel ? b10.in_ready_o  : b14.in_ready_o;
    assign bz     = sel ? b10.busy_o      : b14.busy_o;
    assign mix    = sel ? b10.mix_en_o    : b14.mix_en_o;
    assign rk_idx = sel ? b10.rk_idx_o    : b14.rk_idx_o;
    assign ob     = sel ? b10.out_block_o : b14.out_block_o;
    assign rs     = sel ? b10.rnd_state_o : b14.rnd_state_o;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ir && n < 50) begin
            step();
            n++;
        end
        chk("ready_timeout", 128'(ir), 128'(1));
    endtask

    task automatic run_block(logic [127:0] pt, logic [127:0] exp, int nr, int hold);
        int n = 0;
        wait_ready();
        chk("idle_rk_idx", 128'(rk_idx), '0);
        iv = 1;
        blk = pt;
        step();
        iv = 0;
        while (!ov && n < 40) begin
            chk("rk_idx", 128'(rk_idx), 128'(n + 1));
            chk("mix_en", 128'(mix), 128'((n + 1) != nr));
            chk("round_ready_busy", 128'({ir, bz}), 128'(2'b01));
            step();
            n++;
        end
        chk("latency", 128'(n), 128'(nr));
        chk("out_block", ob, exp);
        chk("done_rk_mix", 128'({rk_idx, mix}), '0);
        for (int i = 0; i < hold; i++) begin
            iv = 1;
            blk = ~pt;
            step();
            chk("hold_valid_ready", 128'({ov, ir, bz}), 128'(3'b101));
            chk("hold_block", ob, exp);
        end
        iv = 0;
        ordy = 1;
        step();
        ordy = 0;
        chk("post_idle", 128'({ov, ir, bz}), 128'(3'b010));
    endtask

    initial begin
        vec_t tab [6];
        int t1, t2, n;
        logic [127:0] p;
        iv = 0; ordy = 0; flush = 0; sel = 0; blk = '0;
        for (int r = 0; r < 16; r++) begin
            ks14[r] = '0;
            ks10[r] = '0;
            if (r <= 14) ks14[r] = round_key(K256, 8, r);
            if (r <= 10) ks10[r] = round_key(K128, 4, r);
        end
        tab[0] = '{PT, 128'h8ea2b7ca516745bfeafc49904b496089};
        tab[1] = '{'0, aes_ref('0, 0)};
        tab[2] = '{'1, aes_ref('1, 0)};
        for (int i = 3; i < 6; i++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            tab[i] = '{p, aes_ref(p, 0)};
        end

        #17;
        chk("rst_flags", 128'({ov, ir, bz, mix}), 128'(4'b0100));
        chk("rst_rk_idx", 128'(rk_idx), '0);
        chk("rst_state", rs, '0);
        @(negedge clk);
        rst_n = 1;
        step();

        for (int i = 0; i < 6; i++) run_block(tab[i].pt, tab[i].ct, 14, $urandom_range(0, 3));

        run_block(tab[1].pt, tab[1].ct, 14, 5);

        wait_ready();
        ordy = 1;
        iv = 1;
        blk = tab[2].pt;
        step();
        blk = tab[3].pt;
        n = 0;
        while (!ov && n < 40) begin step(); n++; end
        t1 = cyc;
        chk("b2b_first", ob, tab[2].ct);
        step();
        n = 0;
        while (!ov && n < 40) begin step(); n++; end
        t2 = cyc;
        chk("b2b_period", 128'(t2 - t1), 128'(16));
        chk("b2b_second", ob, tab[3].ct);
        iv = 0;
        step();
        ordy = 0;
        step();

        wait_ready();
        iv = 1;
        blk = tab[4].pt;
        step();
        iv = 0;
        n = 0;
        while (rk_idx != 4'd7 && n < 20) begin step(); n++; end
        chk("flush_reach7", 128'(rk_idx), 128'(7));
        flush = 1;
        step();
        flush = 0;
        chk("flush_flags", 128'({ov, ir, bz, mix}), 128'(4'b0100));
        chk("flush_rk_idx", 128'(rk_idx), '0);
        chk("flush_state", rs, '0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ov) n++;
        end
        chk("flush_no_valid", 128'(n), '0);
        run_block(tab[4].pt, tab[4].ct, 14, 0);

        flush = 1;
        iv = 1;
        blk = tab[5].pt;
        step();
        flush = 0;
        iv = 0;
        chk("flush_iv_flags", 128'({ov, ir, bz}), 128'(3'b010));
        chk("flush_iv_state", rs, '0);
        step();
        chk("flush_iv_idle", 128'({ir, bz}), 128'(2'b10));

        iv = 1;
        blk = tab[3].pt;
        step();
        iv = 0;
        repeat (5) step();
        #3 rst_n = 0;
        #1;
        chk("arst_flags", 128'({ov, ir, bz, mix}), 128'(4'b0100));
        chk("arst_rk_idx", 128'(rk_idx), '0);
        chk("arst_state", rs, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
        run_block(tab[0].pt, tab[0].ct, 14, 1);

        sel = 1;
        run_block(PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0);
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(p, aes_ref(p, 1), 10, 2);
        sel = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
